commit_watchdog: RTL and testbench
==================================

// Module: commit_watchdog
// PURPOSE
//  Parametrised multi-channel retirement monitor for the mp4 pipeline. Sits beside the WB stage.
//  Per cycle, taps up to NUM_CH in-order commit slots and assigns each an RVFI order number.
//  Detects the branch/jal-to-self halt idiom and a no-commit stall timeout, both as sticky status.
//  Replaces ad-hoc bench halt/timeout logic; synthesizable, usable by rvfi hookup and the bench.
// PARAMETERS
//  NUM_CH   2     commit slots per cycle (1..8), slot 0 oldest
//  XLEN     32    PC width
//  ORDER_W  64    order counter width
//  TIMEOUT  1000  idle cycles (no commit) before timed_out; 0 disables the watchdog
// PORTS
//  clk            in   1              clock, rising edge
//  rst            in   1              asynchronous, active-low reset
//  clr            in   1              sync clear: state->RUN, idle count->0, order kept
//  commit_valid   in   NUM_CH         slot i retires this cycle
//  commit_ctrl    in   NUM_CH         slot i is op_br or op_jal
//  commit_pc      in   NUM_CH*XLEN    retiring PC, slot i at [i*XLEN +: XLEN]
//  commit_next_pc in   NUM_CH*XLEN    PC written by slot i
//  order_o        out  NUM_CH*ORDER_W order number of slot i (comb)
//  halt           out  1              comb: halt detected this cycle
//  halted         out  1              sticky, registered
//  timed_out      out  1              sticky, registered
//  protocol_err   out  1              sticky: non-contiguous commit_valid seen
//  idle_cnt       out  $clog2(TIMEOUT+2)  cycles since last commit
// BEHAVIOUR
//  - Reset: order_q=0, idle_cnt=0, state=RUN, halted/timed_out/protocol_err=0. order_o=0 while valid=0.
//  - FSM: RUN -> HALTED on halt. RUN -> TIMED_OUT when idle_cnt==TIMEOUT-1 with no commit.
//    HALTED and TIMED_OUT hold until clr or rst. clr in RUN only zeroes idle_cnt.
//  - Order: order_o[i] = order_q + popcount(eff_valid[i-1:0]).
//    order_q += popcount(eff_valid) each RUN cycle. Wraps mod 2^ORDER_W.
//  - halt: asserted in RUN when some valid slot k has commit_ctrl and commit_pc==commit_next_pc.
//    Lowest such k is used. Same cycle as the commit, zero latency.
//  - eff_valid: commit_valid masked to slots <=k on a halt cycle. Slot k is counted.
//    Younger slots in that cycle are dropped.
//  - Outside RUN: eff_valid=0, order_q frozen, halt=0.
//  - Idle: any eff_valid resets idle_cnt to 0, else idle_cnt increments; saturates, no wrap.
//  - Simultaneous halt and timeout threshold in one cycle: the commit resets idle_cnt, so halt wins.
//  - Contiguity: valid[i] && !valid[i-1] sets protocol_err. Counting still uses the popcount.
//  - rst mid-cycle clears all state immediately. clr and a halt in the same cycle: clr wins, state=RUN.
// CONFIGURATION
//  COMMIT_WDOG_PERF_EN defined: adds output slot_cnt (NUM_CH*32), a per-slot retire counter.
//    It increments on eff_valid[i], resets with rst, and clr does not clear it.
//    It also adds multi_cnt (32), which counts cycles with popcount(eff_valid)>=2.
//  Macro undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package commit_wdog_pkg holds:
//    enum wdog_state_t {WD_RUN, WD_HALTED, WD_TIMED_OUT}
//    function automatic popcount
//    localparam MAX_CH=8
//  Sub-module commit_prefix_count #(NUM_CH) computes exclusive prefix popcounts and the total;
//  the top level instantiates it once.
// TESTING
//  1 rst low 3 cycles, then NUM_CH=2 with valid=2'b11 for 4 cycles
//    -> order_o pairs (0,1),(2,3),(4,5),(6,7); idle_cnt=0.
//  2 valid=01, ctrl=01, pc=next_pc=0x60 -> halt=1 that cycle, halted=1 next cycle.
//    order stops advancing; later commits give no order change.
//  3 halt on slot 0 with valid=11 -> order_q +1 only; slot 1 dropped.
//  4 TIMEOUT=10, no commits -> timed_out=1 after the 10th idle edge.
//    A commit on cycle 9 instead -> timed_out=0 and idle_cnt=0.
//  5 valid=10 -> protocol_err=1 next cycle and sticky.
//    Then clr -> state RUN and protocol_err still 1 (sticky until rst).
//  6 Preload order_q to 2^64-1 via 1 commit after forced init, valid=11
//    -> order_o=(2^64-1,0), order_q=1.

Source files
------------

// File: rtl/commit_wdog_pkg.sv
// rtl/commit_wdog_pkg.sv - shared state type, sizing constants and popcount for commit_watchdog
package commit_wdog_pkg;

  localparam int MAX_CH = 8;
  localparam int CNT_W  = $clog2(MAX_CH + 1);

  typedef enum logic [1:0] {
    WD_RUN       = 2'd0,
    WD_HALTED    = 2'd1,
    WD_TIMED_OUT = 2'd2
  } wdog_state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/commit_prefix_count.sv
// rtl/commit_prefix_count.sv - exclusive prefix popcounts and total over the commit slots
module commit_prefix_count
  import commit_wdog_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]            valid,
  output logic [NUM_CH-1:0][CNT_W-1:0] prefix,
  output logic [CNT_W-1:0]             total
);

  logic [MAX_CH-1:0] valid_ext;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_CH-1:0]    = valid;
    total                    = popcount(valid_ext);
    prefix                   = '0;
    // slot i sees only the slots older than itself
    for (int i = 0; i < NUM_CH; i++) begin
      prefix[i] = popcount(valid_ext & ((MAX_CH'(1) << i) - MAX_CH'(1)));
    end
  end

endmodule

// File: rtl/commit_watchdog.sv
// rtl/commit_watchdog.sv - multi-slot retirement monitor: order numbering, halt idiom, stall timeout
// Optional COMMIT_WDOG_PERF_EN adds per-slot retire counters and a multi-retire cycle counter.
module commit_watchdog
  import commit_wdog_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int XLEN    = 32,
  parameter  int ORDER_W = 64,
  parameter  int TIMEOUT = 1000,
  localparam int IDLE_W  = $clog2(TIMEOUT + 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [NUM_CH-1:0]         commit_valid,
  input  logic [NUM_CH-1:0]         commit_ctrl,
  input  logic [NUM_CH*XLEN-1:0]    commit_pc,
  input  logic [NUM_CH*XLEN-1:0]    commit_next_pc,
  output logic [NUM_CH*ORDER_W-1:0] order_o,
  output logic                      halt,
  output logic                      halted,
  output logic                      timed_out,
  output logic                      protocol_err,
  output logic [IDLE_W-1:0]         idle_cnt
`ifdef COMMIT_WDOG_PERF_EN
  ,
  output logic [NUM_CH*32-1:0]      slot_cnt,
  output logic [31:0]               multi_cnt
`endif
);

  localparam bit                TO_EN    = (TIMEOUT != 0);
  localparam logic [IDLE_W-1:0] TO_THR   = IDLE_W'(TO_EN ? TIMEOUT - 1 : 0);
  localparam logic [IDLE_W-1:0] IDLE_MAX = '1;

  wdog_state_t                 state_q, state_d;
  logic [ORDER_W-1:0]          order_q, order_d;
  logic [IDLE_W-1:0]           idle_q, idle_d;
  logic                        perr_q, perr_d;

  logic                        in_run;
  logic                        halt_seen;
  logic                        gap;
  logic [NUM_CH-1:0]           slot_match;
  logic [NUM_CH-1:0]           eff_valid;
  logic [NUM_CH-1:0][CNT_W-1:0] eff_prefix;
  logic [CNT_W-1:0]            eff_total;

  assign in_run = (state_q == WD_RUN);

  // Slots younger than the first self-loop branch are dropped; the branch itself still retires.
  always_comb begin
    slot_match = '0;
    eff_valid  = '0;
    halt_seen  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      slot_match[i] = commit_valid[i] && commit_ctrl[i] &&
                      (commit_pc[i*XLEN +: XLEN] == commit_next_pc[i*XLEN +: XLEN]);
      eff_valid[i]  = in_run && commit_valid[i] && !halt_seen;
      halt_seen     = halt_seen | (in_run && slot_match[i]);
    end
  end

  always_comb begin
    gap = 1'b0;
    for (int i = 1; i < NUM_CH; i++) begin
      gap = gap | (commit_valid[i] && !commit_valid[i-1]);
    end
  end

  commit_prefix_count #(
    .NUM_CH (NUM_CH)
  ) u_prefix (
    .valid  (eff_valid),
    .prefix (eff_prefix),
    .total  (eff_total)
  );

  always_comb begin
    state_d = state_q;
    order_d = order_q + ORDER_W'(eff_total);
    idle_d  = idle_q;
    perr_d  = perr_q | gap;

    if (|eff_valid) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    // A halting commit always carries a retire, so it can never coincide with a timeout.
    if (in_run) begin
      if (halt_seen) begin
        state_d = WD_HALTED;
      end else if (TO_EN && !(|eff_valid) && (idle_q == TO_THR)) begin
        state_d = WD_TIMED_OUT;
      end
    end

    if (clr) begin
      state_d = WD_RUN;
      idle_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WD_RUN;
      order_q <= '0;
      idle_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      idle_q  <= idle_d;
      perr_q  <= perr_d;
    end
  end

  // Order numbers are presented for every raw-valid slot so a frozen counter stays visible.
  always_comb begin
    order_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (commit_valid[i]) begin
        order_o[i*ORDER_W +: ORDER_W] = order_q + ORDER_W'(eff_prefix[i]);
      end
    end
  end

  assign halt         = halt_seen;
  assign halted       = (state_q == WD_HALTED);
  assign timed_out    = (state_q == WD_TIMED_OUT);
  assign protocol_err = perr_q;
  assign idle_cnt     = idle_q;

`ifdef COMMIT_WDOG_PERF_EN
  logic [NUM_CH-1:0][31:0] slot_cnt_q, slot_cnt_d;
  logic [31:0]             multi_cnt_q, multi_cnt_d;

  always_comb begin
    slot_cnt_d = slot_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      slot_cnt_d[i] = slot_cnt_q[i] + 32'(eff_valid[i]);
    end
    multi_cnt_d = multi_cnt_q + 32'(eff_total >= CNT_W'(2));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_q  <= '0;
      multi_cnt_q <= '0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      multi_cnt_q <= multi_cnt_d;
    end
  end

  assign slot_cnt  = slot_cnt_q;
  assign multi_cnt = multi_cnt_q;
`endif

endmodule

// File: tb/tb_commit_watchdog.sv
// tb/tb_commit_watchdog.sv - self-checking bench for commit_watchdog (NUM_CH=2, TIMEOUT=10)
module tb_commit_watchdog;

  localparam int NUM_CH  = 2;
  localparam int XLEN    = 32;
  localparam int ORDER_W = 64;
  localparam int TIMEOUT = 10;
  localparam int IDLE_W  = 4;
  localparam int M_RUN   = 0;
  localparam int M_HALT  = 1;
  localparam int M_TO    = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      clr = 1'b0;
  logic [NUM_CH-1:0]         commit_valid = '0;
  logic [NUM_CH-1:0]         commit_ctrl = '0;
  logic [NUM_CH*XLEN-1:0]    commit_pc = '0;
  logic [NUM_CH*XLEN-1:0]    commit_next_pc = '0;
  logic [NUM_CH*ORDER_W-1:0] order_o;
  logic                      halt;
  logic                      halted;
  logic                      timed_out;
  logic                      protocol_err;
  logic [IDLE_W-1:0]         idle_cnt;
`ifdef COMMIT_WDOG_PERF_EN
  logic [NUM_CH*32-1:0]      slot_cnt;
  logic [31:0]               multi_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  commit_watchdog #(
    .NUM_CH  (NUM_CH),
    .XLEN    (XLEN),
    .ORDER_W (ORDER_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .commit_valid   (commit_valid),
    .commit_ctrl    (commit_ctrl),
    .commit_pc      (commit_pc),
    .commit_next_pc (commit_next_pc),
    .order_o        (order_o),
    .halt           (halt),
    .halted         (halted),
    .timed_out      (timed_out),
    .protocol_err   (protocol_err),
    .idle_cnt       (idle_cnt)
`ifdef COMMIT_WDOG_PERF_EN
    ,
    .slot_cnt       (slot_cnt),
    .multi_cnt      (multi_cnt)
`endif
  );

  // Reference model: architectural state plus what this cycle's inputs imply.
  logic [63:0] m_order;
  int          m_idle;
  int          m_state;
  bit          m_perr;
  bit          force_req = 1'b0;
  logic [63:0] force_val = '0;

  bit          p_halt;
  int          p_n;
  logic [63:0] p_o0;
  logic [63:0] p_o1;

  function automatic void predict(output bit h, output int n,
                                  output logic [63:0] o0, output logic [63:0] o1);
    h  = 1'b0;
    n  = 0;
    o0 = '0;
    o1 = '0;
    for (int s = 0; s < 2; s++) begin
      logic [31:0] p;
      logic [31:0] q;
      p = commit_pc[s*32 +: 32];
      q = commit_next_pc[s*32 +: 32];
      if (commit_valid[s]) begin
        if (s == 0) o0 = m_order + 64'(n);
        else        o1 = m_order + 64'(n);
      end
      if (m_state == M_RUN && commit_valid[s] && !h) begin
        n = n + 1;
        if (commit_ctrl[s] && p == q) h = 1'b1;
      end
    end
  endfunction

  always_comb begin
    predict(p_halt, p_n, p_o0, p_o1);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_order <= '0;
      m_idle  <= 0;
      m_state <= M_RUN;
      m_perr  <= 1'b0;
    end else begin
      if (force_req) m_order <= force_val;
      else           m_order <= m_order + 64'(p_n);
      if (commit_valid == 2'b10) m_perr <= 1'b1;
      if (p_n > 0 || clr)  m_idle <= 0;
      else if (m_idle < 15) m_idle <= m_idle + 1;
      if (clr)                                                m_state <= M_RUN;
      else if (m_state == M_RUN && p_halt)                    m_state <= M_HALT;
      else if (m_state == M_RUN && p_n == 0 && m_idle == TIMEOUT - 1) m_state <= M_TO;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] c,
                       input logic [31:0] pc0, input logic [31:0] npc0,
                       input logic [31:0] pc1, input logic [31:0] npc1,
                       input logic cl);
    @(posedge clk);
    #1;
    commit_valid   = v;
    commit_ctrl    = c;
    commit_pc      = {pc1, pc0};
    commit_next_pc = {npc1, npc0};
    clr            = cl;
    #2;
  endtask

  task automatic plain(input logic [1:0] v, input logic cl);
    drive(v, 2'b00, 32'h100, 32'h104, 32'h104, 32'h108, cl);
  endtask

  task automatic self_loop(input logic [1:0] v, input logic cl);
    drive(v, 2'b01, 32'h60, 32'h60, 32'h64, 32'h68, cl);
  endtask

  initial begin
    fork
      begin : model_compare
        forever begin
          @(negedge clk);
          chk("order0",    order_o[63:0],          p_o0);
          chk("order1",    order_o[127:64],        p_o1);
          chk("halt",      64'(halt),              64'(p_halt));
          chk("halted",    64'(halted),            64'(m_state == M_HALT));
          chk("timed_out", 64'(timed_out),         64'(m_state == M_TO));
          chk("perr",      64'(protocol_err),      64'(m_perr));
          chk("idle_cnt",  64'(idle_cnt),          64'(m_idle));
        end
      end
      begin : stimulus
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) plain(2'b00, 1'b0);
        chk("rst_idle",   64'(idle_cnt), 64'd0);
        chk("rst_halted", 64'(halted),   64'd0);
        chk("rst_order",  order_o[63:0], 64'd0);
        rst = 1'b1;

        // back-to-back dual retires
        for (int i = 0; i < 4; i++) begin
          plain(2'b11, 1'b0);
          chk("pair_lo", order_o[63:0],   64'(2 * i));
          chk("pair_hi", order_o[127:64], 64'(2 * i + 1));
        end
        chk("idle_after_pairs", 64'(idle_cnt), 64'd0);

        // halt on slot 0 with slot 1 valid: only slot 0 counts
        self_loop(2'b11, 1'b0);
        chk("halt_s0",       64'(halt),       64'd1);
        chk("halt_s0_ord0",  order_o[63:0],   64'd8);
        chk("halt_s0_ord1",  order_o[127:64], 64'd9);
        plain(2'b11, 1'b0);
        chk("halted_next",   64'(halted),     64'd1);
        chk("frozen_ord0",   order_o[63:0],   64'd9);
        chk("frozen_ord1",   order_o[127:64], 64'd9);
        plain(2'b11, 1'b0);
        chk("still_frozen",  order_o[63:0],   64'd9);

        // clr back to RUN, then single-slot halt
        plain(2'b00, 1'b1);
        plain(2'b00, 1'b0);
        chk("clr_unhalts",   64'(halted),     64'd0);
        self_loop(2'b01, 1'b0);
        chk("halt_single",   64'(halt),       64'd1);
        chk("halt_single_o", order_o[63:0],   64'd9);
        plain(2'b01, 1'b0);
        chk("halted_single", 64'(halted),     64'd1);
        chk("order_kept",    order_o[63:0],   64'd10);
        plain(2'b01, 1'b0);
        chk("no_advance",    order_o[63:0],   64'd10);

        // clr and halt together: clr wins but the halting slot still retires
        plain(2'b00, 1'b1);
        plain(2'b00, 1'b0);
        self_loop(2'b01, 1'b1);
        chk("clr_halt_comb", 64'(halt),       64'd1);
        plain(2'b01, 1'b0);
        chk("clr_wins",      64'(halted),     64'd0);
        chk("clr_halt_ord",  order_o[63:0],   64'd11);

        // idle timeout at the threshold
        plain(2'b00, 1'b1);
        for (int i = 1; i <= 11; i++) begin
          plain(2'b00, 1'b0);
          if (i == 10) begin
            chk("to_before",     64'(timed_out), 64'd0);
            chk("to_idle_9",     64'(idle_cnt),  64'd9);
          end
        end
        chk("to_after", 64'(timed_out), 64'd1);

        // a commit exactly on the threshold cycle prevents the timeout
        plain(2'b00, 1'b1);
        for (int i = 1; i <= 9; i++) plain(2'b00, 1'b0);
        plain(2'b01, 1'b0);
        plain(2'b00, 1'b0);
        chk("to_saved",      64'(timed_out), 64'd0);
        chk("to_saved_idle", 64'(idle_cnt),  64'd0);

        // non-contiguous valid
        plain(2'b10, 1'b0);
        chk("gap_order1",    order_o[127:64], 64'd13);
        plain(2'b00, 1'b0);
        chk("perr_set",      64'(protocol_err), 64'd1);
        plain(2'b00, 1'b1);
        plain(2'b00, 1'b0);
        chk("perr_sticky",   64'(protocol_err), 64'd1);

        // order wrap from a forced preload
        plain(2'b00, 1'b0);
        force dut.order_q = 64'hFFFF_FFFF_FFFF_FFFE;
        force_val = 64'hFFFF_FFFF_FFFF_FFFE;
        force_req = 1'b1;
        plain(2'b00, 1'b0);
        release dut.order_q;
        force_req = 1'b0;
        plain(2'b01, 1'b0);
        chk("wrap_pre",  order_o[63:0],   64'hFFFF_FFFF_FFFF_FFFE);
        plain(2'b11, 1'b0);
        chk("wrap_lo",   order_o[63:0],   64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_hi",   order_o[127:64], 64'd0);
        plain(2'b01, 1'b0);
        chk("wrap_next", order_o[63:0],   64'd1);

        // asynchronous reset mid-cycle
        #1 rst = 1'b0;
        #1;
        chk("arst_order", order_o[63:0],     64'd0);
        chk("arst_perr",  64'(protocol_err), 64'd0);
        chk("arst_idle",  64'(idle_cnt),     64'd0);
        plain(2'b00, 1'b0);
        rst = 1'b1;
        plain(2'b11, 1'b0);
        chk("post_rst_lo", order_o[63:0],   64'd0);
        chk("post_rst_hi", order_o[127:64], 64'd1);
        plain(2'b00, 1'b0);
        plain(2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join_any
  end

endmodule
